// File: rtl/rx_fifo_axis_pkg.sv
// Shared types, default sizes and helpers for the receive-FIFO AXI-Stream self-test.
package rx_fifo_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_NUM_WORDS  = 64;

  // Word counters cover up to 2^16-1 words per transaction
  localparam int unsigned CNT_W = 16;

  // Pointer width: one extra MSB distinguishes full from empty
  function automatic int unsigned ptr_width(input int unsigned depth);
    return 32'($clog2(depth) + 1);
  endfunction

endpackage

// File: rtl/rx_fifo_axis_top_fifo.sv
// Register-array AXI-Stream FIFO carrying data plus tlast, with synchronous flush.
module axis_fifo
  import rx_fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  localparam int unsigned PTR_W  = ptr_width(FIFO_DEPTH);
  localparam int unsigned ADDR_W = PTR_W - 1;

  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                full_c;
  logic                empty_c;
  logic                wr_en_c;
  logic                rd_en_c;

  // Full when the wrap bits differ and the address bits match
  assign full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);

  assign s_tready = ~full_c;
  assign m_tvalid = ~empty_c;
  assign {m_tlast, m_tdata} = mem_q[rd_ptr_q[ADDR_W-1:0]];

  assign wr_en_c = s_tvalid & ~full_c;
  assign rd_en_c = m_tvalid & m_tready;

  // Pointer next-state: flush empties the FIFO, otherwise advance on handshakes
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (wr_en_c && !flush) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_tlast, s_tdata};
    end
  end

endmodule

// File: rtl/rx_fifo_axis_top.sv
// Self-test top: start edge detector, control FSM, incrementing stream source and checking sink.
module rx_fifo_axis_top
  import rx_fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned NUM_WORDS   = DEF_NUM_WORDS,
  parameter int unsigned START_VALUE = 1,
  parameter int unsigned THROTTLE    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_axi_txn,
  output logic compare_done,
  output logic error_out
);

  localparam logic [CNT_W-1:0]      WORDS    = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] START_W  = DATA_WIDTH'(START_VALUE);

  state_e                state_q, state_d;
  logic                  init_q;
  logic                  start_c;
  logic                  flush_c;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic                  tog_q, tog_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  src_tvalid;
  logic                  src_tready;
  logic                  src_tlast;
  logic [DATA_WIDTH-1:0] src_tdata;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tlast;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  src_fire_c;
  logic                  rx_fire_c;
  logic                  rx_is_last_c;

  // A held request produces a single start pulse
  assign start_c = init_axi_txn & ~init_q;

  // Request history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= init_axi_txn;
  end

  // Source: incrementing words straight from the registered counter, so stable while stalled
  assign src_tvalid = (state_q == RUN) && (tx_cnt_q < WORDS);
  assign src_tdata  = START_W + DATA_WIDTH'(tx_cnt_q);
  assign src_tlast  = (tx_cnt_q == LAST_IDX);
  assign src_fire_c = src_tvalid & src_tready;

  // Sink: ready every cycle, or on alternate cycles to back up the FIFO
  assign m_tready     = (state_q == RUN) && ((THROTTLE == 0) || tog_q);
  assign rx_fire_c    = m_tvalid & m_tready;
  assign rx_is_last_c = (rx_cnt_q == LAST_IDX);

  // A new run empties whatever a previous run may have left behind
  assign flush_c = start_c && (state_q != RUN);

  axis_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_c),
    .s_tdata  (src_tdata),
    .s_tlast  (src_tlast),
    .s_tvalid (src_tvalid),
    .s_tready (src_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  // Next-state: run control, counters, throttle toggle and sticky result flags
  always_comb begin
    state_d  = state_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    tog_d    = tog_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_c) begin
          state_d  = RUN;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          tog_d    = 1'b0;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      RUN: begin
        tog_d = ~tog_q;
        if (src_fire_c) tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (rx_fire_c) begin
          if (m_tdata != START_W + DATA_WIDTH'(rx_cnt_q)) err_d = 1'b1;
          if (m_tlast != rx_is_last_c)                    err_d = 1'b1;
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
          if (rx_is_last_c)            done_d  = 1'b1;
          // A corrupted tlast still must not leave the FSM stuck in RUN
          if (m_tlast || rx_is_last_c) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tog_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tog_q    <= tog_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign compare_done = done_q;
  assign error_out    = err_q;

endmodule

// File: tb/tb_rx_fifo_axis_top.sv
// Randomized self-checking bench for rx_fifo_axis_top against a queue-based stream model.
module tb_rx_fifo_axis_top;

  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned N      = 64;
  localparam int unsigned START  = 1;
  localparam int unsigned THR    = 1;
  localparam int          BUDGET = (THR != 0) ? int'(2 * N + 4) : int'(N + 4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic compare_done;
  logic error_out;

  always #10 clk = ~clk;

  rx_fifo_axis_top #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .NUM_WORDS   (N),
    .START_VALUE (START),
    .THROTTLE    (THR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_axi_txn (init),
    .compare_done (compare_done),
    .error_out    (error_out)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] wq[$];
  int          tx_words;
  int          rx_words;
  int          inj_idx = -1;
  bit          full_seen;
  bit          mon_en = 1'b0;
  logic [31:0] mon_exp;
  logic [31:0] mon_out;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: every word entering the FIFO must leave it once, in order, with the expected value
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (dut.src_tvalid && !dut.src_tready) full_seen = 1'b1;
      if (dut.src_tvalid && dut.src_tready) begin
        check_eq("src_data", dut.src_tdata, 32'(START + 32'(tx_words)));
        wq.push_back(dut.src_tdata);
        tx_words++;
      end
      if (dut.m_tvalid && dut.m_tready) begin
        check_eq("fifo_occupied", 32'(wq.size() != 0), 32'd1);
        mon_exp = (wq.size() != 0) ? wq.pop_front() : 32'hFFFF_FFFF;
        check_eq("fifo_order", mon_exp, 32'(START + 32'(rx_words)));
        mon_out = (rx_words == inj_idx) ? 32'h0000_DEAD : mon_exp;
        check_eq("rx_data", dut.m_tdata, mon_out);
        check_eq("rx_last", 32'(dut.m_tlast), 32'(rx_words == int'(N) - 1));
        rx_words++;
      end
    end
  end

  // One transaction: pulse width pw edges, optional extra pulse at cycle ign,
  // optional corruption of word inj, optional reset once rst_at words were received
  task automatic run_txn(input int pw, input int ign, input int inj, input int rst_at,
                         input bit from_done);
    int cyc;
    bit forced;
    bit injected;
    bit done_seen;
    wq.delete();
    tx_words  = 0;
    rx_words  = 0;
    full_seen = 1'b0;
    inj_idx   = inj;
    forced    = 1'b0;
    injected  = 1'b0;
    done_seen = 1'b0;
    mon_en    = 1'b1;
    @(posedge clk); #2;
    init = 1'b1;
    @(posedge clk); #2;
    cyc = 0;
    if (from_done) begin
      check_eq("restart_clears_done", 32'(compare_done), 32'd0);
      check_eq("restart_clears_err", 32'(error_out), 32'd0);
    end
    if (pw <= 1) init = 1'b0;
    while (!done_seen && cyc < BUDGET) begin
      @(posedge clk); #2;
      cyc++;
      if (cyc + 1 >= pw) init = 1'b0;
      if (ign >= 0 && cyc == ign)     init = 1'b1;
      if (ign >= 0 && cyc == ign + 2) init = 1'b0;
      if (forced) begin
        release dut.m_tdata;
        forced = 1'b0;
      end
      if (inj >= 0 && !injected && int'(dut.rx_cnt_q) == inj && dut.m_tvalid && dut.m_tready) begin
        force dut.m_tdata = 32'h0000_DEAD;
        forced   = 1'b1;
        injected = 1'b1;
      end
      if (rst_at >= 0 && rx_words >= rst_at) begin
        rst_n = 1'b0;
        init  = 1'b0;
        #1;
        check_eq("rst_done", 32'(compare_done), 32'd0);
        check_eq("rst_err", 32'(error_out), 32'd0);
        check_eq("rst_src_valid", 32'(dut.src_tvalid), 32'd0);
        check_eq("rst_fifo_empty", 32'(dut.m_tvalid), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_hold_valid", 32'(dut.src_tvalid | dut.m_tvalid), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("post_rst_idle", 32'(dut.src_tvalid | dut.m_tready), 32'd0);
        return;
      end
      done_seen = compare_done;
    end
    init = 1'b0;
    check_eq("done_in_budget", 32'(done_seen), 32'd1);
    check_eq("err_result", 32'(error_out), 32'(inj >= 0 && inj < int'(N)));
    check_eq("tx_count", 32'(tx_words), 32'(N));
    check_eq("rx_count", 32'(rx_words), 32'(N));
    check_eq("model_drained", 32'(wq.size()), 32'd0);
    check_eq("fifo_empty_end", 32'(dut.m_tvalid), 32'd0);
    if (THR != 0 && N > DEPTH) check_eq("fifo_went_full", 32'(full_seen), 32'd1);
    repeat (8) @(posedge clk);
    #2;
    check_eq("done_sticky", 32'(compare_done), 32'd1);
    check_eq("no_extra_words", 32'(rx_words), 32'(N));
    mon_en = 1'b0;
  endtask

  initial begin
    int pw;
    int ign;
    int inj;
    int rst_at;
    bit in_done;
    rst_n = 1'b0;
    init  = 1'b0;
    #500;
    check_eq("reset_done", 32'(compare_done), 32'd0);
    check_eq("reset_err", 32'(error_out), 32'd0);
    check_eq("reset_valid", 32'(dut.src_tvalid), 32'd0);
    rst_n = 1'b1;
    #50;

    run_txn(3, -1, -1, -1, 1'b0);   // default run, 3-edge pulse
    run_txn(2, 30, -1, -1, 1'b1);   // extra pulse during RUN is ignored
    run_txn(1, -1, 10, -1, 1'b1);   // corrupt word 10
    run_txn(4, -1, -1, -1, 1'b1);   // clean rerun clears the error
    run_txn(2, -1, -1, 20, 1'b1);   // reset mid-run at word 20
    run_txn(3, -1, -1, -1, 1'b0);   // clean run after reset

    in_done = 1'b1;
    for (int it = 0; it < 6; it++) begin
      pw     = int'($urandom_range(1, 5));
      ign    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(pw + 1, 100)) : -1;
      inj    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 2)) : -1;
      repeat ($urandom_range(0, 6)) @(posedge clk);
      run_txn(pw, ign, inj, rst_at, in_done);
      in_done = (rst_at < 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
